mfifo_sync_grp: RTL and testbench

MFIFO_SYNC_GRP -- requirements
Module: mfifo_sync_grp

---
 rtl/mfifo_sync_pkg.sv | 33 +++
 rtl/mfifo_sync_chn.sv | 47 ++++
 rtl/mfifo_sync_grp.sv | 156 +++++++++++++++
 tb/tb_mfifo_sync_grp.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfifo_sync_pkg.sv
// Shared types and sizing helpers for the synchronous group forwarder.
package mfifo_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int MODE_PKT  = 0;
    localparam int MODE_CELL = 1;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Counter width able to hold v-1, never narrower than one bit.
    function automatic int cnt_w(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

    // Timeout counter must reach TMO_CYC-1.
    function automatic int tmo_w(input int tmo);
        return cnt_w(tmo);
    endfunction

endpackage

// File: rtl/mfifo_sync_chn.sv
// Per-channel tracker: active flag, beat counter and end-of-group detect.
module mfifo_sync_chn
    import mfifo_sync_pkg::*;
#(
    parameter int MODE   = MODE_PKT,
    parameter int CELLSZ = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic xfer,
    input  logic eop,
    output logic active,
    output logic ending
);

    localparam int              CW   = cnt_w(CELLSZ);
    localparam logic [CW-1:0]   LAST = CW'(CELLSZ - 1);

    logic [CW-1:0] cnt;
    logic          hit;

    // Packet channels end on the EOP flag, cell channels on the last beat of a cell.
    assign hit    = (MODE == MODE_CELL) ? (cnt == LAST) : eop;
    assign ending = xfer & hit;

    // Beat counter within the current cell; wraps to zero on the ending beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (xfer) begin
            cnt <= ending ? '0 : cnt + 1'b1;
        end
    end

    // A channel that ends on the start beat never becomes active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
        end else if (start) begin
            active <= ~ending;
        end else if (ending) begin
            active <= 1'b0;
        end
    end

endmodule

// File: rtl/mfifo_sync_grp.sv
// Group-synchronous forwarder: starts all packet and cell channels together,
// passes beats through until every channel has ended, with timeout flush.
module mfifo_sync_grp
    import mfifo_sync_pkg::*;
#(
    parameter int PKT_CHN_NUM  = 2,
    parameter int PDWID        = 128,
    parameter int PMWID        = 32,
    parameter int EOP_BIT      = 0,
    parameter int CELL_CHN_NUM = 2,
    parameter int CDWID        = 128,
    parameter int CELLSZ       = 4,
    parameter int TMO_CYC      = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PKT_CHN_NUM-1:0]           in_pkt_vld,
    output logic [PKT_CHN_NUM-1:0]           in_pkt_rdy,
    input  logic [PKT_CHN_NUM*PDWID-1:0]     in_pkt_dat,
    input  logic [PKT_CHN_NUM*PMWID-1:0]     in_pkt_msg,
    output logic [PKT_CHN_NUM-1:0]           out_pkt_vld,
    input  logic [PKT_CHN_NUM-1:0]           out_pkt_rdy,
    output logic [PKT_CHN_NUM*PDWID-1:0]     out_pkt_dat,
    output logic [PKT_CHN_NUM*PMWID-1:0]     out_pkt_msg,
    input  logic [CELL_CHN_NUM-1:0]          in_cell_vld,
    output logic [CELL_CHN_NUM-1:0]          in_cell_rdy,
    input  logic [CELL_CHN_NUM*CDWID-1:0]    in_cell_dat,
    output logic [CELL_CHN_NUM-1:0]          out_cell_vld,
    input  logic [CELL_CHN_NUM-1:0]          out_cell_rdy,
    output logic [CELL_CHN_NUM*CDWID-1:0]    out_cell_dat,
    output logic                             busy,
    output logic                             grp_done,
    output logic                             tmo_err,
    output logic [15:0]                      grp_cnt
);

    localparam int NCH = PKT_CHN_NUM + CELL_CHN_NUM;
    localparam int TW  = tmo_w(TMO_CYC);

    state_t          state;
    logic [TW-1:0]   tcnt;
    logic [NCH-1:0]  ch_in_vld;
    logic [NCH-1:0]  ch_out_rdy;
    logic [NCH-1:0]  ch_in_rdy;
    logic [NCH-1:0]  ch_out_vld;
    logic [NCH-1:0]  ch_xfer;
    logic [NCH-1:0]  ch_eop;
    logic [NCH-1:0]  ch_active;
    logic [NCH-1:0]  ch_ending;
    logic            start;
    logic            all_done;
    logic            tmo_hit;

    assign ch_in_vld  = {in_cell_vld, in_pkt_vld};
    assign ch_out_rdy = {out_cell_rdy, out_pkt_rdy};
    assign ch_xfer    = ch_in_vld & ch_in_rdy;

    // A group starts only when every source and every sink is ready at once.
    assign start    = (state == ST_IDLE) & ~rst & (&ch_in_vld) & (&ch_out_rdy);
    assign all_done = &(~ch_active | ch_ending);
    assign tmo_hit  = (TMO_CYC > 0) && (tcnt >= TW'(TMO_CYC - 1));

    assign busy     = (state != ST_IDLE);
    assign grp_done = (state == ST_RUN) & all_done;
    assign tmo_err  = (state == ST_RUN) & ~all_done & tmo_hit;

    // Handshake gating: pass-through while running, sink-only while flushing.
    always_comb begin
        ch_in_rdy  = '0;
        ch_out_vld = '0;
        if (!rst) begin
            if (state == ST_FLUSH) begin
                ch_in_rdy = ch_active;
            end else begin
                ch_in_rdy  = ch_out_rdy & (ch_active | {NCH{start}});
                ch_out_vld = ch_in_vld  & (ch_active | {NCH{start}});
            end
        end
    end

    assign in_pkt_rdy   = ch_in_rdy[PKT_CHN_NUM-1:0];
    assign in_cell_rdy  = ch_in_rdy[NCH-1:PKT_CHN_NUM];
    assign out_pkt_vld  = ch_out_vld[PKT_CHN_NUM-1:0];
    assign out_cell_vld = ch_out_vld[NCH-1:PKT_CHN_NUM];

    assign out_pkt_dat  = in_pkt_dat;
    assign out_pkt_msg  = in_pkt_msg;
    assign out_cell_dat = in_cell_dat;

    for (genvar i = 0; i < PKT_CHN_NUM; i++) begin : g_pkt
        assign ch_eop[i] = in_pkt_msg[i*PMWID + EOP_BIT];
        mfifo_sync_chn #(
            .MODE   (MODE_PKT),
            .CELLSZ (CELLSZ)
        ) u_chn (
            .clk    (clk),
            .rst    (rst),
            .start  (start),
            .xfer   (ch_xfer[i]),
            .eop    (ch_eop[i]),
            .active (ch_active[i]),
            .ending (ch_ending[i])
        );
    end

    for (genvar j = 0; j < CELL_CHN_NUM; j++) begin : g_cell
        assign ch_eop[PKT_CHN_NUM + j] = 1'b0;
        mfifo_sync_chn #(
            .MODE   (MODE_CELL),
            .CELLSZ (CELLSZ)
        ) u_chn (
            .clk    (clk),
            .rst    (rst),
            .start  (start),
            .xfer   (ch_xfer[PKT_CHN_NUM + j]),
            .eop    (ch_eop[PKT_CHN_NUM + j]),
            .active (ch_active[PKT_CHN_NUM + j]),
            .ending (ch_ending[PKT_CHN_NUM + j])
        );
    end

    // Group sequencing; completion wins over a coincident timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tcnt    <= '0;
            grp_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        tcnt  <= TW'(1);
                    end
                end
                ST_RUN: begin
                    if (all_done) begin
                        state   <= ST_IDLE;
                        tcnt    <= '0;
                        grp_cnt <= grp_cnt + 16'd1;
                    end else if (tmo_hit) begin
                        state <= ST_FLUSH;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (all_done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mfifo_sync_grp.sv
// Scoreboard bench for mfifo_sync_grp: source queues drive the inputs,
// expected beats are queued at issue time and popped by a monitor.
module tb_mfifo_sync_grp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main DUT: 2 pkt + 2 cell channels, CELLSZ=4, TMO_CYC=16.
    logic [1:0]  in_pkt_vld, in_pkt_rdy, out_pkt_vld, out_pkt_rdy;
    logic [31:0] in_pkt_dat, out_pkt_dat;
    logic [15:0] in_pkt_msg, out_pkt_msg;
    logic [1:0]  in_cell_vld, in_cell_rdy, out_cell_vld, out_cell_rdy;
    logic [31:0] in_cell_dat, out_cell_dat;
    logic        busy, grp_done, tmo_err;
    logic [15:0] grp_cnt;

    mfifo_sync_grp #(
        .PKT_CHN_NUM(2), .PDWID(16), .PMWID(8), .EOP_BIT(0),
        .CELL_CHN_NUM(2), .CDWID(16), .CELLSZ(4), .TMO_CYC(16)
    ) dut (
        .clk(clk), .rst(rst),
        .in_pkt_vld(in_pkt_vld), .in_pkt_rdy(in_pkt_rdy),
        .in_pkt_dat(in_pkt_dat), .in_pkt_msg(in_pkt_msg),
        .out_pkt_vld(out_pkt_vld), .out_pkt_rdy(out_pkt_rdy),
        .out_pkt_dat(out_pkt_dat), .out_pkt_msg(out_pkt_msg),
        .in_cell_vld(in_cell_vld), .in_cell_rdy(in_cell_rdy), .in_cell_dat(in_cell_dat),
        .out_cell_vld(out_cell_vld), .out_cell_rdy(out_cell_rdy), .out_cell_dat(out_cell_dat),
        .busy(busy), .grp_done(grp_done), .tmo_err(tmo_err), .grp_cnt(grp_cnt)
    );

    // Second DUT: single-beat packets and CELLSZ=1, timeout disabled.
    logic       b_en = 1'b0;
    logic       b_ordy = 1'b1;
    logic       b_in_pkt_rdy, b_out_pkt_vld, b_in_cell_rdy, b_out_cell_vld;
    logic [7:0] b_out_pkt_dat, b_out_pkt_msg, b_out_cell_dat;
    logic       b_busy, b_grp_done, b_tmo_err;
    logic [15:0] b_grp_cnt;
    logic [7:0] b_pdat = 8'hA5;
    logic [7:0] b_pmsg = 8'h01;
    logic [7:0] b_cdat = 8'h3C;

    mfifo_sync_grp #(
        .PKT_CHN_NUM(1), .PDWID(8), .PMWID(8), .EOP_BIT(0),
        .CELL_CHN_NUM(1), .CDWID(8), .CELLSZ(1), .TMO_CYC(0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .in_pkt_vld(b_en), .in_pkt_rdy(b_in_pkt_rdy),
        .in_pkt_dat(b_pdat), .in_pkt_msg(b_pmsg),
        .out_pkt_vld(b_out_pkt_vld), .out_pkt_rdy(b_ordy),
        .out_pkt_dat(b_out_pkt_dat), .out_pkt_msg(b_out_pkt_msg),
        .in_cell_vld(b_en), .in_cell_rdy(b_in_cell_rdy), .in_cell_dat(b_cdat),
        .out_cell_vld(b_out_cell_vld), .out_cell_rdy(b_ordy), .out_cell_dat(b_out_cell_dat),
        .busy(b_busy), .grp_done(b_grp_done), .tmo_err(b_tmo_err), .grp_cnt(b_grp_cnt)
    );

    // Channel order: 0,1 = pkt; 2,3 = cell. Entry = {msg, dat}.
    logic [23:0] src_q [4][$];
    logic [23:0] exp_q [4][$];
    logic        drv_vld [4];
    logic [15:0] drv_dat [4];
    logic [7:0]  drv_msg [4];
    logic [3:0]  rnd_rdy = 4'hF;
    logic [3:0]  force_low = 4'h0;
    bit          rdy_mode = 1'b0;
    bit          tmo_ok = 1'b0;
    int          seq = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_cnt = 0;

    assign in_pkt_vld   = {drv_vld[1], drv_vld[0]};
    assign in_pkt_dat   = {drv_dat[1], drv_dat[0]};
    assign in_pkt_msg   = {drv_msg[1], drv_msg[0]};
    assign in_cell_vld  = {drv_vld[3], drv_vld[2]};
    assign in_cell_dat  = {drv_dat[3], drv_dat[2]};
    assign out_pkt_rdy  = rnd_rdy[1:0] & ~force_low[1:0];
    assign out_cell_rdy = rnd_rdy[3:2] & ~force_low[3:2];

    logic [3:0] in_rdy_all, out_vld_all, out_rdy_all, vld_vec;
    assign in_rdy_all  = {in_cell_rdy, in_pkt_rdy};
    assign out_vld_all = {out_cell_vld, out_pkt_vld};
    assign out_rdy_all = {out_cell_rdy, out_pkt_rdy};
    assign vld_vec     = {drv_vld[3], drv_vld[2], drv_vld[1], drv_vld[0]};

    function automatic logic [23:0] out_val(input int ch);
        if (ch < 2) return {out_pkt_msg[ch*8 +: 8], out_pkt_dat[ch*16 +: 16]};
        return {8'h00, out_cell_dat[(ch-2)*16 +: 16]};
    endfunction

    function automatic int exp_left();
        int n;
        n = 0;
        for (int c = 0; c < 4; c++) n += exp_q[c].size();
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic push_beat(input int ch, input logic [7:0] msg, input bit to_exp);
        logic [23:0] w;
        w = {msg, ch[3:0], seq[11:0]};
        seq++;
        src_q[ch].push_back(w);
        if (to_exp) exp_q[ch].push_back(w);
    endtask

    task automatic push_pkt(input int ch, input int len, input bit to_exp, input bit eop_last);
        for (int i = 0; i < len; i++)
            push_beat(ch, {i[6:0], (eop_last && i == len - 1)}, to_exp);
    endtask

    task automatic push_grp(input int l0, input int l1);
        push_pkt(0, l0, 1'b1, 1'b1);
        push_pkt(1, l1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) push_beat(2, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) push_beat(3, 8'h00, 1'b1);
    endtask

    task automatic wait_start(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && in_rdy_all == 4'hF) begin
                at = cyc;
                break;
            end
        end
        chk("start_seen", at >= 0, 1);
    endtask

    task automatic wait_evt(input bit want_tmo, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (want_tmo ? tmo_err : grp_done) begin
                at = cyc;
                break;
            end
        end
        chk(want_tmo ? "tmo_seen" : "done_seen", at >= 0, 1);
    endtask

    // Source driver: retire beats accepted at the last edge, present the next.
    initial begin
        logic [3:0] take;
        forever begin
            @(negedge clk);
            take = in_rdy_all & vld_vec;
            @(posedge clk);
            for (int c = 0; c < 4; c++)
                if (take[c] && !rst && src_q[c].size() > 0) void'(src_q[c].pop_front());
            #1;
            for (int c = 0; c < 4; c++) begin
                drv_vld[c] = (src_q[c].size() > 0);
                if (src_q[c].size() > 0) {drv_msg[c], drv_dat[c]} = src_q[c][0];
                if (rdy_mode) rnd_rdy[c] = !rnd_rdy[c] ? 1'b1 : ($urandom_range(0, 2) != 0);
                else          rnd_rdy[c] = 1'b1;
            end
        end
    end

    // Monitor: every delivered beat must match the head of its expected queue.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tmo_err && !tmo_ok) chk("tmo_unexpected", tmo_err, 0);
                for (int c = 0; c < 4; c++) begin
                    if (out_vld_all[c] && out_rdy_all[c]) begin
                        if (exp_q[c].size() == 0) begin
                            chk($sformatf("extra_beat_ch%0d", c), {8'h0, out_val(c)}, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q[c].pop_front();
                            chk($sformatf("beat_ch%0d", c), {8'h0, out_val(c)}, {8'h0, e});
                        end
                    end
                end
            end
        end
    end

    initial begin
        int s, d, at;
        for (int c = 0; c < 4; c++) begin
            drv_vld[c] = 1'b0;
            drv_dat[c] = '0;
            drv_msg[c] = '0;
        end
        // Reset with every source and sink ready: nothing may move.
        b_en = 1'b1;
        push_grp(3, 5);
        exp_cnt = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_rdy", in_rdy_all, 0);
        chk("rst_out_vld", out_vld_all, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grp_cnt", grp_cnt, 0);
        chk("rst_b_rdy", {b_in_pkt_rdy, b_in_cell_rdy, b_out_pkt_vld, b_out_cell_vld}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Group of 3/5-beat packets and 4-beat cells; dut_b cycles single-beat groups.
        s = -1;
        d = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("s1_start", {busy, in_rdy_all}, 5'h0F);
                s = cyc;
                chk("b_start0", {b_busy, b_in_pkt_rdy, b_in_cell_rdy, b_out_pkt_vld, b_out_cell_vld}, 5'b01111);
                chk("b_pass", {b_out_pkt_msg, b_out_pkt_dat, b_out_cell_dat}, 24'h01A53C);
            end
            if (i == 1) begin
                chk("b_run_done", {b_busy, b_grp_done, b_tmo_err, b_in_pkt_rdy}, 4'b1100);
            end
            if (i == 2) begin
                chk("b_restart", {b_busy, b_in_pkt_rdy}, 2'b01);
                chk("b_cnt1", b_grp_cnt, 1);
            end
            if (i == 3) b_en = 1'b0;
            if (grp_done && d < 0) d = cyc;
        end
        chk("s1_done_lat", d - s, 4);
        chk("s1_grp_cnt", grp_cnt, 1);
        chk("s1_drain", exp_left(), 0);
        chk("b_cnt2", b_grp_cnt, 2);

        // One sink held off: no start; release starts the group the same cycle.
        force_low = 4'b1000;
        push_grp(2, 2);
        exp_cnt++;
        repeat (3) @(negedge clk);
        chk("s2_no_start", {busy, in_rdy_all}, 0);
        @(posedge clk);
        #1 force_low = 4'b0000;
        @(negedge clk);
        chk("s2_start", {busy, in_rdy_all}, 5'h0F);
        s = cyc;
        wait_evt(1'b0, 20, d);
        chk("s2_done_lat", d - s, 3);
        @(negedge clk);
        chk("s2_grp_cnt", grp_cnt, 2);

        // Packet channel 1 stalls without EOP: timeout, then flush to its EOP.
        tmo_ok = 1'b1;
        push_pkt(0, 3, 1'b1, 1'b1);
        push_pkt(1, 2, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push_beat(2, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) push_beat(3, 8'h00, 1'b1);
        wait_start(20, s);
        wait_evt(1'b1, 30, d);
        chk("s3_tmo_lat", d - s, 15);
        chk("s3_no_done", grp_done, 0);
        push_pkt(1, 3, 1'b0, 1'b1);
        @(negedge clk);
        chk("s3_flush", {busy, out_vld_all, in_rdy_all[1]}, 6'b100001);
        at = -1;
        for (int i = 0; i < 10; i++) begin
            if (!busy) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("s3_flush_exit", at - s, 19);
        chk("s3_grp_cnt", grp_cnt, 2);
        chk("s3_drain", exp_left(), 0);
        tmo_ok = 1'b0;

        // Reset three cycles into a group, then a fresh group.
        push_grp(5, 5);
        wait_start(20, s);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("s4_rst_async", {busy, in_rdy_all, out_vld_all}, 0);
        chk("s4_rst_cnt", grp_cnt, 0);
        for (int c = 0; c < 4; c++) begin
            src_q[c].delete();
            exp_q[c].delete();
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_grp(2, 3);
        exp_cnt = 1;
        wait_start(20, s);
        wait_evt(1'b0, 20, d);
        chk("s4_done_lat", d - s, 3);
        @(negedge clk);
        chk("s4_grp_cnt", grp_cnt, 1);

        // Random sink backpressure over 1000 groups.
        rdy_mode = 1'b1;
        for (int g = 0; g < 1000; g++) begin
            push_grp($urandom_range(1, 5), $urandom_range(1, 5));
            exp_cnt++;
            wait_start(300, s);
            wait_evt(1'b0, 40, d);
        end
        rdy_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("s5_grp_cnt", grp_cnt, exp_cnt % 65536);
        chk("s5_drain", exp_left(), 0);
        chk("s5_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
